regfile_arbiter: RTL and testbench

Two-client access arbiter and clear sequencer for the 16-entry, 18-bit, two-read/one-write register file. Client A (datapath control) and client B (debug/loader) each issue single-cycle read-pair or write transactions. A round-robin arbiter grants at most one transaction per cycle and drives the register file ports. A clear FSM can zero every register through the normal write port, so the register file needs no asynchronous reset of its own.

---
 rtl/regfile_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Two-client round-robin access arbiter for a 2-read/1-write register file,
// plus a sequencer that zeroes every entry through the normal write port.
module regfile_arbiter #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] waddr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic [ADDR_WIDTH-1:0] raddr1_a,
  input  logic [ADDR_WIDTH-1:0] raddr2_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] waddr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  input  logic [ADDR_WIDTH-1:0] raddr1_b,
  input  logic [ADDR_WIDTH-1:0] raddr2_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rsp_valid_a,
  output logic                  rsp_valid_b,
  output logic [DATA_WIDTH-1:0] rsp_data1,
  output logic [DATA_WIDTH-1:0] rsp_data2,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  rf_register_write,
  output logic [ADDR_WIDTH-1:0] rf_write_register,
  output logic [DATA_WIDTH-1:0] rf_input_data,
  output logic [ADDR_WIDTH-1:0] rf_read_register1,
  output logic [ADDR_WIDTH-1:0] rf_read_register2,
  input  logic [DATA_WIDTH-1:0] rf_register_data1,
  input  logic [DATA_WIDTH-1:0] rf_register_data2
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic [0:0] {SERVE = 1'b0, CLEAR = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  last_q, last_d;  // 1: client B holds the most recent grant
  logic                  clear_done_q, clear_done_d;
  logic                  rsp_valid_a_q, rsp_valid_a_d;
  logic                  rsp_valid_b_q, rsp_valid_b_d;
  logic [DATA_WIDTH-1:0] rsp_data1_q, rsp_data1_d;
  logic [DATA_WIDTH-1:0] rsp_data2_q, rsp_data2_d;
  logic                  read_grant;

  // Arbitration and register file port drive; everything is quiet in reset.
  always_comb begin
    gnt_a             = 1'b0;
    gnt_b             = 1'b0;
    read_grant        = 1'b0;
    rf_register_write = 1'b0;
    rf_write_register = '0;
    rf_input_data     = '0;
    rf_read_register1 = '0;
    rf_read_register2 = '0;
    if (!reset) begin
      case (state_q)
        SERVE: begin
          if (!clear_req) begin
            gnt_a = req_a && (!req_b || last_q);
            gnt_b = req_b && !gnt_a;
            if (gnt_a || gnt_b) begin
              if (gnt_b ? we_b : we_a) begin
                rf_register_write = 1'b1;
                rf_write_register = gnt_b ? waddr_b : waddr_a;
                rf_input_data     = gnt_b ? wdata_b : wdata_a;
              end else begin
                read_grant        = 1'b1;
                rf_read_register1 = gnt_b ? raddr1_b : raddr1_a;
                rf_read_register2 = gnt_b ? raddr2_b : raddr2_a;
              end
            end
          end
        end
        CLEAR: begin
          rf_register_write = 1'b1;
          rf_write_register = count_q;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic for the clear sequencer, round-robin pointer and responses.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    last_d        = last_q;
    clear_done_d  = 1'b0;
    rsp_valid_a_d = 1'b0;
    rsp_valid_b_d = 1'b0;
    rsp_data1_d   = rsp_data1_q;
    rsp_data2_d   = rsp_data2_q;
    case (state_q)
      SERVE: begin
        if (clear_req) begin
          state_d = CLEAR;
          count_d = '0;
        end
        if (gnt_a || gnt_b) begin
          last_d = gnt_b;
        end
        if (read_grant) begin
          rsp_valid_a_d = gnt_a;
          rsp_valid_b_d = gnt_b;
          rsp_data1_d   = rf_register_data1;
          rsp_data2_d   = rf_register_data2;
        end
      end
      CLEAR: begin
        count_d = count_q + ADDR_WIDTH'(1);
        if (count_q == LAST_ADDR) begin
          state_d      = SERVE;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= SERVE;
      count_q       <= '0;
      last_q        <= 1'b1;
      clear_done_q  <= 1'b0;
      rsp_valid_a_q <= 1'b0;
      rsp_valid_b_q <= 1'b0;
      rsp_data1_q   <= '0;
      rsp_data2_q   <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      last_q        <= last_d;
      clear_done_q  <= clear_done_d;
      rsp_valid_a_q <= rsp_valid_a_d;
      rsp_valid_b_q <= rsp_valid_b_d;
      rsp_data1_q   <= rsp_data1_d;
      rsp_data2_q   <= rsp_data2_d;
    end
  end

  // A response still in flight when reset rises is dropped immediately.
  assign rsp_valid_a = rsp_valid_a_q && !reset;
  assign rsp_valid_b = rsp_valid_b_q && !reset;
  assign rsp_data1   = rsp_data1_q;
  assign rsp_data2   = rsp_data2_q;
  assign busy        = (state_q == CLEAR);
  assign clear_done  = clear_done_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: a behavioural register file, directed
// stimulus pushing expected grants/responses, and a monitor that pops them.
module tb_regfile_arbiter;
  localparam int unsigned DW = 18;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_a, we_a, req_b, we_b, clear_req;
  logic [AW-1:0] waddr_a, raddr1_a, raddr2_a, waddr_b, raddr1_b, raddr2_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rsp_valid_a, rsp_valid_b, busy, clear_done;
  logic [DW-1:0] rsp_data1, rsp_data2;
  logic          rf_register_write;
  logic [AW-1:0] rf_write_register, rf_read_register1, rf_read_register2;
  logic [DW-1:0] rf_input_data, rf_register_data1, rf_register_data2;

  typedef struct packed {
    logic          cl;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } rsp_t;

  logic gnt_exp[$];
  rsp_t rsp_exp[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  regfile_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .raddr1_a(raddr1_a), .raddr2_a(raddr2_a),
    .req_b(req_b), .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr1_b(raddr1_b), .raddr2_b(raddr2_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rsp_valid_a(rsp_valid_a), .rsp_valid_b(rsp_valid_b),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .clear_req(clear_req), .busy(busy), .clear_done(clear_done),
    .rf_register_write(rf_register_write), .rf_write_register(rf_write_register),
    .rf_input_data(rf_input_data),
    .rf_read_register1(rf_read_register1), .rf_read_register2(rf_read_register2),
    .rf_register_data1(rf_register_data1), .rf_register_data2(rf_register_data2)
  );

  // Behavioural 16x18 register file: write at the edge, combinational reads.
  logic [DW-1:0] rf_mem [NR] = '{default: '0};
  always @(posedge clock) if (rf_register_write) rf_mem[rf_write_register] <= rf_input_data;
  assign rf_register_data1 = rf_mem[rf_read_register1];
  assign rf_register_data2 = rf_mem[rf_read_register2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every grant and every response must match the next expectation.
  always @(negedge clock) begin
    if (gnt_a || gnt_b) begin
      if (gnt_a && gnt_b) chk("gnt_overlap", 32'd1, 32'd0);
      else if (gnt_exp.size() == 0) chk("gnt_unexpected", {31'd0, gnt_b}, 32'hFFFF_FFFF);
      else chk("gnt_order", {31'd0, gnt_b}, {31'd0, gnt_exp.pop_front()});
    end
    if (rsp_valid_a || rsp_valid_b) begin
      if (rsp_valid_a && rsp_valid_b) chk("rsp_overlap", 32'd1, 32'd0);
      else if (rsp_exp.size() == 0) chk("rsp_unexpected", {31'd0, rsp_valid_b}, 32'hFFFF_FFFF);
      else begin
        rsp_t e;
        e = rsp_exp.pop_front();
        chk("rsp_client", {31'd0, rsp_valid_b}, {31'd0, e.cl});
        chk("rsp_data1", 32'(rsp_data1), 32'(e.d1));
        chk("rsp_data2", 32'(rsp_data2), 32'(e.d2));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] fillv(input int i);
    return 18'h20000 + 18'(i * 37 + 1);
  endfunction

  task automatic push_rsp(input logic cl, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    rsp_t r;
    r.cl = cl;
    r.d1 = d1;
    r.d2 = d2;
    rsp_exp.push_back(r);
  endtask

  task automatic a_wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    req_a = 1'b1; we_a = 1'b1; waddr_a = wa; wdata_a = wd;
    gnt_exp.push_back(1'b0);
    tick();
    req_a = 1'b0;
  endtask

  task automatic a_rd(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    req_a = 1'b1; we_a = 1'b0; raddr1_a = r1; raddr2_a = r2;
    gnt_exp.push_back(1'b0);
    push_rsp(1'b0, d1, d2);
    tick();
    req_a = 1'b0;
  endtask

  task automatic b_wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    req_b = 1'b1; we_b = 1'b1; waddr_b = wa; wdata_b = wd;
    gnt_exp.push_back(1'b1);
    tick();
    req_b = 1'b0;
  endtask

  task automatic b_rd(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    req_b = 1'b1; we_b = 1'b0; raddr1_b = r1; raddr2_b = r2;
    gnt_exp.push_back(1'b1);
    push_rsp(1'b1, d1, d2);
    tick();
    req_b = 1'b0;
  endtask

  initial begin
    int done_cnt;
    int done_at;
    reset = 1'b1; clear_req = 1'b0;
    req_b = 1'b0; we_b = 1'b0; waddr_b = '0; wdata_b = '0; raddr1_b = '0; raddr2_b = '0;
    // A request during reset must not be granted or reach the register file
    req_a = 1'b1; we_a = 1'b1; waddr_a = 4'd1; wdata_a = 18'h00001; raddr1_a = '0; raddr2_a = '0;
    tick(); tick();
    @(negedge clock);
    chk("rst_gnt_a", 32'(gnt_a), 32'd0);
    chk("rst_rf_we", 32'(rf_register_write), 32'd0);
    chk("rst_rf_waddr", 32'(rf_write_register), 32'd0);
    chk("rst_rf_wdata", 32'(rf_input_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    chk("rst_rsp_valid_a", 32'(rsp_valid_a), 32'd0);
    chk("rst_rsp_data1", 32'(rsp_data1), 32'd0);
    tick();
    reset = 1'b0; req_a = 1'b0;
    tick();

    // Contention: both write r8 for 4 cycles, grant order A,B,A,B
    req_a = 1'b1; we_a = 1'b1; waddr_a = 4'd8; wdata_a = 18'h0AAAA;
    req_b = 1'b1; we_b = 1'b1; waddr_b = 4'd8; wdata_b = 18'h15555;
    gnt_exp.push_back(1'b0); gnt_exp.push_back(1'b1);
    gnt_exp.push_back(1'b0); gnt_exp.push_back(1'b1);
    repeat (4) tick();
    req_a = 1'b0; req_b = 1'b0;
    a_rd(4'd8, 4'd3, 18'h15555, 18'h00000);

    // Write then read-back by A; r0 never written
    a_wr(4'd3, 18'h2A5F5);
    a_rd(4'd3, 4'd0, 18'h2A5F5, 18'h00000);

    // B writes, A reads the next cycle and sees the new value
    b_wr(4'd5, 18'h3FFFF);
    a_rd(4'd5, 4'd3, 18'h3FFFF, 18'h2A5F5);
    b_rd(4'd8, 4'd5, 18'h15555, 18'h3FFFF);
    tick();

    // Full clear with B's read held pending across it
    for (int i = 0; i < 16; i++) a_wr(4'(i), fillv(i));
    clear_req = 1'b1;
    req_b = 1'b1; we_b = 1'b0; raddr1_b = 4'd0; raddr2_b = 4'd15;
    gnt_exp.push_back(1'b1);
    push_rsp(1'b1, 18'h00000, 18'h00000);
    @(negedge clock);
    chk("clr_req_no_grant", 32'(gnt_b), 32'd0);
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_gnt_b", 32'(gnt_b), 32'd0);
      chk("clr_rf_we", 32'(rf_register_write), 32'd1);
      chk("clr_rf_waddr", 32'(rf_write_register), 32'(k));
      chk("clr_rf_wdata", 32'(rf_input_data), 32'd0);
      tick();
    end
    @(negedge clock);
    chk("clr_done_pulse", 32'(clear_done), 32'd1);
    chk("clr_done_busy", 32'(busy), 32'd0);
    chk("clr_done_gnt_b", 32'(gnt_b), 32'd1);
    tick();
    req_b = 1'b0;
    @(negedge clock);
    chk("clr_done_one_cycle", 32'(clear_done), 32'd0);
    for (int i = 0; i < 8; i++) a_rd(4'(2 * i), 4'(2 * i + 1), 18'h00000, 18'h00000);

    // Reset on the 8th clear write aborts the clear
    for (int i = 0; i < 16; i++) a_wr(4'(i), fillv(i));
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    @(negedge clock);
    chk("abort_rf_we", 32'(rf_register_write), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (clear_done) done_cnt++;
      tick();
    end
    chk("abort_no_clear_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < 16; i++)
      a_rd(4'(i), 4'(i), (i < 7) ? 18'h00000 : fillv(i), (i < 7) ? 18'h00000 : fillv(i));

    // Reset the cycle after a read grant suppresses its response
    req_a = 1'b1; we_a = 1'b0; raddr1_a = 4'd9; raddr2_a = 4'd10;
    gnt_exp.push_back(1'b0);
    tick();
    req_a = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk("rst_rsp_suppressed", 32'(rsp_valid_a), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_rsp_valid_after", 32'(rsp_valid_a), 32'd0);
    chk("rst_rsp_data_cleared", 32'(rsp_data1), 32'd0);

    // clear_req re-pulsed mid-clear is ignored: one clear_done at T+17
    tick();
    clear_req = 1'b1;
    tick();
    done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 25; c++) begin
      clear_req = (c == 5);
      @(negedge clock);
      if (clear_done) begin
        done_cnt++;
        done_at = c;
      end
      tick();
    end
    clear_req = 1'b0;
    chk("repulse_done_count", 32'(done_cnt), 32'd1);
    chk("repulse_done_cycle", 32'(done_at), 32'd17);

    repeat (5) tick();
    chk("gnt_queue_drained", 32'(gnt_exp.size()), 32'd0);
    chk("rsp_queue_drained", 32'(rsp_exp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
